part_select_stage: RTL and testbench

PART_SELECT_STAGE -- requirements
Module: part_select_stage

---
 rtl/part_select_stage.sv | 109 ++++++++++
 tb/tb_part_select_stage.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/part_select_stage.sv
// Extracts a fixed bit field from each word, right-justifies and extends it, and passes it
// through a 2-entry skid buffer with a registered in_ready and a saturating transfer counter.
module part_select_stage #(
    parameter int   DATA_W   = 16,
    parameter int   SEL_MSB  = 15,
    parameter int   SEL_LSB  = 8,
    parameter logic SIGN_EXT = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [15:0]       out_count
);

    if (SEL_LSB < 0 || SEL_LSB > SEL_MSB || SEL_MSB >= DATA_W) begin : g_bad_params
        $fatal(1, "part_select_stage: need 0 <= SEL_LSB <= SEL_MSB < DATA_W");
    end

    localparam int FW = SEL_MSB - SEL_LSB + 1;
    localparam logic [DATA_W-1:0] FieldMask = {DATA_W{1'b1}} >> (DATA_W - FW);
    // Single bit at the top of the right-justified field.
    localparam logic [DATA_W-1:0] SignMask = FieldMask ^ (FieldMask >> 1);

    typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] head_q, head_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              in_ready_q, in_ready_d;
    logic [15:0]       count_q, count_d;

    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] ext;
    logic              fill;
    logic              push;
    logic              pop;

    always_comb begin
        shifted = in_data >> SEL_LSB;
        fill    = SIGN_EXT && ((shifted & SignMask) != '0);
        ext     = (shifted & FieldMask) | (fill ? ~FieldMask : '0);
    end

    assign out_valid = (state_q != StEmpty);
    assign in_ready  = in_ready_q;
    assign out_data  = head_q;
    assign out_count = count_q;
    assign push      = in_valid && in_ready_q;
    assign pop       = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        count_d = count_q;
        case (state_q)
            StEmpty: begin
                if (push) begin
                    state_d = StOne;
                    head_d  = ext;
                end
            end
            StOne: begin
                if (push && !pop) begin
                    state_d = StTwo;
                    skid_d  = ext;
                end else if (pop && !push) begin
                    state_d = StEmpty;
                end else if (push && pop) begin
                    head_d = ext;
                end
            end
            StTwo: begin
                // in_ready is low here, so only a pop can happen.
                if (pop) begin
                    state_d = StOne;
                    head_d  = skid_q;
                end
            end
            default: state_d = StEmpty;
        endcase
        in_ready_d = (state_d != StTwo);
        if (pop && count_q != 16'hFFFF) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StEmpty;
            head_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
            count_q    <= count_d;
        end
    end

endmodule

// File: tb/tb_part_select_stage.sv
// Directed bench for part_select_stage: a default-parameter instance and a sign-extending one.
module tb_part_select_stage;

    logic        clk;
    logic        rst_n;

    logic        in_valid, in_ready, out_valid, out_ready;
    logic [15:0] in_data, out_data, out_count;

    logic        sx_in_valid, sx_in_ready, sx_out_valid, sx_out_ready;
    logic [15:0] sx_in_data, sx_out_data, sx_out_count;

    int n_checks;
    int n_errors;

    part_select_stage dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count)
    );

    part_select_stage #(
        .SIGN_EXT (1'b1)
    ) dut_sx (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (sx_in_valid),
        .in_ready  (sx_in_ready),
        .in_data   (sx_in_data),
        .out_valid (sx_out_valid),
        .out_ready (sx_out_ready),
        .out_data  (sx_out_data),
        .out_count (sx_out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        in_valid     = 1'b0;
        in_data      = '0;
        out_ready    = 1'b0;
        sx_in_valid  = 1'b0;
        sx_in_data   = '0;
        sx_out_ready = 1'b0;
        rst_n        = 1'b1;
        #1 rst_n     = 1'b0;
        tick();

        // Reset values
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_data", 32'(out_data), 32'h0);
        check("rst_out_count", 32'(out_count), 32'd0);
        rst_n = 1'b1;
        #1;
        check("rel_in_ready_pre_edge", 32'(in_ready), 32'd0);
        tick();
        check("rel_in_ready_post_edge", 32'(in_ready), 32'd1);

        // Single word, default field [15:8] zero-extended
        in_valid  = 1'b1;
        in_data   = 16'h1234;
        out_ready = 1'b1;
        tick();
        in_valid  = 1'b0;
        check("single_valid", 32'(out_valid), 32'd1);
        check("single_data", 32'(out_data), 32'h0012);
        tick();
        check("single_count", 32'(out_count), 32'd1);
        check("single_drained", 32'(out_valid), 32'd0);

        // Sign extension, back-to-back words
        sx_out_ready = 1'b1;
        sx_in_valid  = 1'b1;
        sx_in_data   = 16'hA5C3;
        tick();
        check("sx_first", 32'(sx_out_data), 32'hFFA5);
        sx_in_data = 16'h7F00;
        tick();
        sx_in_valid = 1'b0;
        check("sx_second", 32'(sx_out_data), 32'h007F);
        tick();
        check("sx_count", 32'(sx_out_count), 32'd2);

        // Backpressure fills the skid buffer
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'h1100;
        tick();
        check("bp_ready_after_1", 32'(in_ready), 32'd1);
        in_data = 16'h2200;
        tick();
        check("bp_ready_after_2", 32'(in_ready), 32'd0);
        in_data = 16'h3300;
        tick();
        check("bp_hold_ready", 32'(in_ready), 32'd0);
        check("bp_hold_data", 32'(out_data), 32'h0011);
        check("bp_hold_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        tick();
        check("bp_out_2", 32'(out_data), 32'h0022);
        check("bp_ready_back", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check("bp_out_3", 32'(out_data), 32'h0033);
        tick();
        check("bp_empty", 32'(out_valid), 32'd0);
        check("bp_count", 32'(out_count), 32'd4);

        // Streaming 100 words after a fresh reset
        rst_n = 1'b0;
        #1;
        check("rst2_count", 32'(out_count), 32'd0);
        rst_n = 1'b1;
        tick();
        in_valid = 1'b1;
        for (int k = 0; k < 100; k++) begin
            in_data = 16'(k << 8) | 16'h00AA;
            tick();
            check("stream_valid", 32'(out_valid), 32'd1);
            check("stream_data", 32'(out_data), 32'(k));
        end
        in_valid = 1'b0;
        tick();
        check("stream_count", 32'(out_count), 32'd100);
        check("stream_empty", 32'(out_valid), 32'd0);

        // Reset while holding two entries
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'hAB00;
        tick();
        in_data = 16'hCD00;
        tick();
        in_valid = 1'b0;
        check("two_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_count", 32'(out_count), 32'd0);
        check("midrst_data", 32'(out_data), 32'h0);
        rst_n = 1'b1;
        tick();
        check("midrst_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 16'h5500;
        tick();
        in_valid = 1'b0;
        check("midrst_first", 32'(out_data), 32'h0055);
        tick();
        check("midrst_count_after", 32'(out_count), 32'd1);
        check("midrst_drained", 32'(out_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
